// File: rtl/req_ack_pkg.sv
// Shared types and default sizing for the req/ack pulse-handshake blocks.
package req_ack_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_GAP,
        ST_DONE
    } req_state_t;

    localparam int REQ_CNT_W   = 8;
    localparam int REQ_LAT_W   = 4;
    localparam int REQ_MAX_LAT = 8;
    localparam int REQ_GAP_W   = 4;

endpackage

// File: rtl/lat_timer.sv
// Loadable latency counter that stops at MAX_LAT and flags when it gets there.
module lat_timer
    import req_ack_pkg::*;
#(
    parameter int LAT_W   = REQ_LAT_W,
    parameter int MAX_LAT = REQ_MAX_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    input  logic             en,
    output logic [LAT_W-1:0] q,
    output logic             expired
);

    // Holding at MAX_LAT keeps the count from ever wrapping.
    assign expired = (q == LAT_W'(MAX_LAT));

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, exactly like real flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (en && !expired) begin
            q <= q + LAT_W'(1);
        end
    end

endmodule

// File: rtl/req_initiator.sv
// Initiator for the req/ack pulse handshake: issues a burst of req pulses,
// waits for each ack, and keeps latency statistics plus sticky error flags.
module req_initiator
    import req_ack_pkg::*;
#(
    parameter int CNT_W   = REQ_CNT_W,
    parameter int LAT_W   = REQ_LAT_W,
    parameter int MAX_LAT = REQ_MAX_LAT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_req,
    input  logic [REQ_GAP_W-1:0] gap,
    input  logic                 ack,
    output logic                 req,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic                 spurious,
    output logic [CNT_W-1:0]     ack_cnt,
    output logic [LAT_W-1:0]     lat_last,
    output logic [LAT_W-1:0]     lat_max
);

    req_state_t           state;
    logic [CNT_W-1:0]     num_q;
    logic [REQ_GAP_W-1:0] gap_q;
    logic [REQ_GAP_W-1:0] gap_cnt;

    logic [LAT_W-1:0]     lat;
    logic                 lat_expired;
    logic                 last_ack;
    logic [CNT_W-1:0]     ack_cnt_inc;

    lat_timer #(
        .LAT_W   (LAT_W),
        .MAX_LAT (MAX_LAT)
    ) u_lat_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state == ST_REQ),
        .load_val (LAT_W'(1)),
        .en       (state == ST_WAIT),
        .q        (lat),
        .expired  (lat_expired)
    );

    // Widened compare so a full all-ones burst still terminates.
    assign last_ack    = ({1'b0, ack_cnt} + (CNT_W+1)'(1)) == {1'b0, num_q};
    assign ack_cnt_inc = (&ack_cnt) ? ack_cnt : ack_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            num_q    <= '0;
            gap_q    <= '0;
            gap_cnt  <= '0;
            req      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            spurious <= 1'b0;
            ack_cnt  <= '0;
            lat_last <= '0;
            lat_max  <= '0;
        end else begin
            // NOTE: pulse outputs default low each edge; the states below only
            // raise them, so no branch can leave a stale value behind.
            req  <= 1'b0;
            done <= 1'b0;

            if (ack && state != ST_WAIT) begin
                spurious <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        num_q    <= num_req;
                        gap_q    <= gap;
                        ack_cnt  <= '0;
                        lat_last <= '0;
                        lat_max  <= '0;
                        timeout  <= 1'b0;
                        spurious <= ack;
                        busy     <= 1'b1;
                        if (num_req == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_REQ;
                            req   <= 1'b1;
                        end
                    end
                end

                ST_REQ: begin
                    state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (ack) begin
                        lat_last <= lat;
                        lat_max  <= (lat > lat_max) ? lat : lat_max;
                        ack_cnt  <= ack_cnt_inc;
                        if (last_ack) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else if (gap_q == '0) begin
                            state <= ST_REQ;
                            req   <= 1'b1;
                        end else begin
                            state   <= ST_GAP;
                            gap_cnt <= gap_q - REQ_GAP_W'(1);
                        end
                    end else if (lat_expired) begin
                        timeout <= 1'b1;
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= ST_REQ;
                        req   <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - REQ_GAP_W'(1);
                    end
                end

                ST_DONE: begin
                    // Normal bursts raised done on entry; an empty burst arrives
                    // with done low and emits its single pulse on the way out.
                    done  <= ~done;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/req_initiator.md
# req_initiator

Initiator side of the single-bit req/ack pulse handshake. Issues a programmed burst of one-cycle `req` pulses toward a responder and waits for each matching `ack` pulse. Measures per-transaction latency and flags timeouts and spurious acks. Serves as the stimulus/checking partner for fixed-delay responders in the concurrent-assertion examples.

## Interface
- `CNT_W`, 8: width of request count and ack counter.
- `LAT_W`, 4: width of latency values.
- `MAX_LAT`, 8: largest legal ack latency in cycles; must be less than 2^LAT_W.
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that launches a burst; sampled only in IDLE.
- `num_req`  in  CNT_W  number of requests in the burst; latched on accepted `start`.
- `gap`  in  4  idle cycles between an ack and the next req; latched on accepted `start`.
- `ack`  in  1  responder acknowledge pulse.
- `req`  out  1  registered request pulse, high for exactly one cycle per transaction.
- `busy`  out  1  high from the cycle after an accepted `start` until DONE.
- `done`  out  1  one-cycle pulse when the burst ends, normally or by timeout.
- `timeout`  out  1  sticky error; set when an ack is not seen within MAX_LAT; cleared by the next accepted `start`.
- `spurious`  out  1  sticky error; set on `ack` high outside WAIT; cleared by the next accepted `start`.
- `ack_cnt`  out  CNT_W  number of acks accepted in the current burst.
- `lat_last`  out  LAT_W  latency of the most recent accepted ack.
- `lat_max`  out  LAT_W  maximum latency seen in the current burst.

## Operation
- State machine with states IDLE, REQ, WAIT, GAP, DONE.
- IDLE:
  - On `start`, latch `num_req` and `gap`, and clear `ack_cnt`, `lat_last`, `lat_max`, `timeout` and `spurious`.
  - Go to DONE if `num_req`==0, else go to REQ.
- REQ: `req`=1 for this one cycle; the latency counter loads 1; next state is WAIT.
- WAIT:
  - Latency counter L counts edges since the `req` cycle.
  - On an edge with `ack`=1: `lat_last`<=L, `lat_max`<=max(`lat_max`,L), and `ack_cnt`+=1.
  - After an ack: if `ack_cnt`+1==`num_req`, go to DONE; else if `gap`==0, go to REQ; else go to GAP.
  - If `ack`=0 and L==MAX_LAT, set `timeout` and go to DONE.
  - An ack on the same edge where L==MAX_LAT is accepted, not a timeout.
- GAP: wait exactly `gap` cycles, then go to REQ.
- DONE: `done`=1 for one cycle, `busy`=0, then go to IDLE.
- Any `ack`=1 sampled in IDLE, REQ, GAP or DONE sets `spurious`; the FSM ignores it.
- `start` outside IDLE is ignored.
- `ack_cnt` saturates at all-ones (only reachable if `num_req` is all-ones).
- Latency arithmetic is unsigned; L never exceeds MAX_LAT.

## Timing
- Reset values: `req`, `busy`, `done`, `timeout`, `spurious`, `ack_cnt`, `lat_last` and `lat_max` are all 0; FSM is in IDLE.
- `rst` asserted mid-burst returns everything to reset values on the next edge. No `done` pulse is produced. An ack arriving after reset is flagged `spurious`.
- `start` sampled at edge e: `busy` and `req` are high in cycle e+1.
- Latency definition: `req` high in cycle c and `ack` sampled high at the edge ending cycle c+L gives latency L. A 3-stage delay responder yields L=3.
- Back-to-back rate with `gap`=0: one req every L+1 cycles.
- `done` is asserted the cycle after the final ack or timeout edge.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `req_ack_pkg` holds:
  - the state enum `req_state_t`;
  - default constants `REQ_CNT_W`=8, `REQ_LAT_W`=4 and `REQ_MAX_LAT`=8.
- One sub-module, `lat_timer`, is natural. It is a LAT_W-bit counter with load, enable, and a `expired` output that compares against MAX_LAT. It is reusable by future responder checkers.
- The FSM, counters and statistics live in `req_initiator`.

## Test plan
- Basic burst: `num_req`=4, `gap`=0, 3-cycle delay responder.
  - Four `req` pulses 4 cycles apart.
  - `ack_cnt`=4, `lat_last`=`lat_max`=3.
  - `done` pulse one cycle after the 4th ack; no errors.
- Gap: `num_req`=2, `gap`=5.
  - Second `req` comes 6 cycles after the first ack.
  - `ack_cnt`=2.
- Timeout: responder never acks, MAX_LAT=8.
  - `timeout`=1 after L=8.
  - `done` on the following cycle; `ack_cnt`=0.
- Latency boundary: ack at exactly L=8 is accepted (`lat_max`=8, no timeout); ack at L=9 gives `timeout`.
- Spurious ack and zero count:
  - Ack injected in IDLE sets `spurious`=1.
  - A following `start` with `num_req`=0 clears `spurious`, pulses `done` 2 cycles after `start`, and never raises `req`.
- Mid-burst reset: `rst` pulsed during WAIT of request 2.
  - All outputs return to 0 with no `done`.
  - The late ack sets `spurious`; a new `start` completes normally.
